vector_list_sequencer: RTL and testbench
========================================

# vector_list_sequencer

- Sits between the UART receiver and the line-draw controller.
- Assembles 4-byte vector commands from the serial byte stream into a double-buffered display list.
- Replays the front list continuously into the drawer's x/y/draw/jump/ready interface to refresh the display.
- On end-of-frame the buffers swap at the next frame boundary, so the image never tears.

## Interface

- ADDR_W, 10: display-list address width; each buffer holds DEPTH = 2^ADDR_W entries.
- TIMEOUT, 100000: idle clk cycles between bytes after which a partial command is discarded.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- ready  in  1  drawer can accept a command.
- x  out  12  target X, held between pulses.
- y  out  12  target Y, held between pulses.
- draw  out  1  one-cycle pulse: draw line to (x,y).
- jump  out  1  one-cycle pulse: blank move to (x,y).
- swap_pending  out  1  back buffer is closed and waiting for the frame boundary.
- overflow  out  1  sticky flag: a command was dropped.
- frame_start  out  1  one-cycle pulse when replay issues entry 0.

## Operation

- **Command word:** 32 bits, sent MSB byte first.
  - [31:30] op: 00 jump, 01 draw, 10 end-of-frame (EOF), 11 clear.
  - [29:24] ignored.
  - [23:12] x; [11:0] y.
- **Byte assembler:** 2-bit byte counter.
  - The timeout counter restarts on every rx_valid.
  - When it reaches TIMEOUT with the byte counter nonzero, the byte counter returns to 0 and the partial word is discarded.
- **Complete jump/draw:** written as {op[0], x, y} (25 bits) at back_len, then back_len++.
  - If back_len == DEPTH, the command is dropped and overflow=1.
  - If swap_pending=1, the command is dropped and overflow=1.
- **EOF:**
  - If back_len > 0, set swap_pending.
  - If back_len == 0, ignore it.
  - An EOF received while swap_pending=1 is ignored.
- **Clear:** back_len=0, overflow=0, swap_pending=0. The front buffer is unaffected.
- **Swap:** occurs when swap_pending=1 and either the replay wraps past the last front entry or front_len == 0.
  - Front select toggles, front_len=back_len, back_len=0, swap_pending=0.
  - overflow is cleared on swap.
- **Replay FSM:**
  - IDLE: front_len == 0, or waiting for a swap.
  - FETCH: RAM read of index idx, 1-cycle synchronous latency.
  - HOLD: entry latched; wait for ready=1.
  - ISSUE: drive the pulse.
  - BLANK: 2 cycles.
  - Then idx++. If idx == front_len-1, idx=0 and the swap check applies. Then back to FETCH.
- **Output register:** x/y update only in the ISSUE cycle and hold otherwise. draw and jump are never both 1.
- **frame_start:** asserted with the pulse for idx 0.
- **Single-entry frame:** the same entry is reissued every pass.

## Timing

- **Reset values:** x=0, y=0, draw=0, jump=0, swap_pending=0, overflow=0, frame_start=0.
  - front_len=back_len=0, byte counter=0, FSM=IDLE.
  - RAM contents are not cleared.
- **Reset mid-operation:** everything returns to the reset values above; a partial command is lost.
- **Write latency:** RAM write and back_len increment happen in the cycle after the 4th rx_valid.
- **Issue latency:** ready sampled high in HOLD at cycle N → draw/jump=1 and new x/y at N+1.
  - ready is ignored in N+1 (ISSUE) and N+2..N+3 (BLANK).
  - The next HOLD sample is no earlier than N+4 (FETCH occupies N+4, HOLD from N+5).
- **Simultaneous events:**
  - An EOF completing in the same cycle as the replay wrap takes effect at the following wrap.
  - Clear and swap in the same cycle: swap takes priority, then clear applies to the new back buffer.

## Structure

- **Package vector_pkg:**
  - op encodings (OP_JUMP, OP_DRAW, OP_EOF, OP_CLEAR).
  - COORD_W=12.
  - Display-list entry typedef {is_draw, x, y}.
  - Replay state enum.
- **Sub-module vector_list_ram:** simple dual-port memory, depth 2·DEPTH, 25 bits wide, registered read.
  - Address = {buffer select, index}.
  - Write port is owned by the assembler; read port by the replay FSM.
- Top level holds the assembler, the buffer/swap logic and the replay FSM.

## Test plan

- **Reset, then idle:** ready held 1 and no bytes → no draw/jump pulses for 1000 cycles; x=y=0.
- **Load and replay:** jump (4095,400), draw (0,3695), EOF, with ready held 1.
  - Pulses alternate: jump@(4095,400), draw@(0,3695), repeating.
  - frame_start is asserted with each jump.
  - Pulse spacing is 5 cycles.
- **Swap:** during replay of a 2-entry frame, load a 3-entry frame plus EOF.
  - The old frame completes its pass.
  - The next pulse is new entry 0 with frame_start.
  - swap_pending falls in the same cycle the front select toggles.
- **Overflow:** with ADDR_W=2, send 5 draws plus EOF.
  - Only the first 4 replay.
  - overflow=1 until the swap, then 0.
- **Timeout resync:** send 2 bytes, idle TIMEOUT+1 cycles, then send a full draw (100,200) and EOF.
  - Exactly one draw@(100,200) replays.
  - No misaligned commands.
- **Ready throttling and reset mid-frame:**
  - Hold ready=0 for 50 cycles → no pulse.
  - Raise ready → pulse one cycle later.
  - Assert reset mid-BLANK → all outputs return to their reset values and no further pulses occur.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types for the vector display-list sequencer: command opcodes, list
// entry layout and replay state encoding.
package vector_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned ENTRY_W = 1 + 2 * COORD_W;

  typedef enum logic [1:0] {
    OP_JUMP  = 2'b00,
    OP_DRAW  = 2'b01,
    OP_EOF   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // One display-list entry as stored in the list RAM.
  typedef struct packed {
    logic               is_draw;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } entry_t;

  // Fully assembled command with the ignored bits already stripped.
  typedef struct packed {
    logic [1:0]         op;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_ISSUE,
    ST_BLANK
  } replay_state_e;

endpackage

// File: rtl/vector_list_ram.sv
// Simple dual-port display-list memory holding both buffers; address MSB is
// the buffer select. Registered read, updated only when rd_en is high.
module vector_list_ram
  import vector_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  entry_t          wr_data,
  input  logic            rd_en,
  input  logic [ADDR_W:0] rd_addr,
  output entry_t          rd_data
);

  localparam int unsigned WORDS = 2 << ADDR_W;

  entry_t mem [WORDS];
  entry_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vector_list_sequencer.sv
// Assembles 4-byte vector commands into a double-buffered display list and
// replays the front list into the line-draw controller, swapping at frame wrap.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  output logic               swap_pending,
  output logic               overflow,
  output logic               frame_start
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      xy_q, xy_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             cmd_vld_q, cmd_vld_d;
  cmd_t             cmd_q, cmd_d;

  logic             front_sel_q, front_sel_d;
  logic [LEN_W-1:0] front_len_q, front_len_d;
  logic [LEN_W-1:0] back_len_q, back_len_d;
  logic             swap_pending_q, swap_pending_d;
  logic             overflow_q, overflow_d;

  replay_state_e     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              blank_q, blank_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic              draw_q, draw_d, jump_q, jump_d, frame_start_q, frame_start_d;

  logic   swap_c, wr_en_c, rd_en_c;
  entry_t wr_data_c, rd_data;

  // Byte assembler with inter-byte timeout resync.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    op_d       = op_q;
    xy_d       = xy_q;
    timer_d    = timer_q;
    cmd_vld_d  = 1'b0;
    cmd_d      = cmd_q;
    if (rx_valid) begin
      timer_d = '0;
      if (byte_cnt_q == 2'd3) begin
        cmd_vld_d  = 1'b1;
        cmd_d      = '{op: op_q, x: xy_q[15:4], y: {xy_q[3:0], rx_byte}};
        byte_cnt_d = 2'd0;
      end else begin
        if (byte_cnt_q == 2'd0) op_d = rx_byte[7:6];
        else                    xy_d = {xy_q[7:0], rx_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else begin
      if (timer_q != TMR_W'(TIMEOUT)) timer_d = timer_q + TMR_W'(1);
      else if (byte_cnt_q != 2'd0)    byte_cnt_d = 2'd0;
    end
  end

  // Buffer bookkeeping; a swap is applied first so a same-cycle clear hits the new back buffer.
  always_comb begin
    front_sel_d    = front_sel_q;
    front_len_d    = front_len_q;
    back_len_d     = back_len_q;
    swap_pending_d = swap_pending_q;
    overflow_d     = overflow_q;
    wr_en_c        = 1'b0;
    wr_data_c      = '{is_draw: cmd_q.op[0], x: cmd_q.x, y: cmd_q.y};
    if (swap_c) begin
      front_sel_d    = ~front_sel_q;
      front_len_d    = back_len_q;
      back_len_d     = '0;
      swap_pending_d = 1'b0;
      overflow_d     = 1'b0;
    end
    if (cmd_vld_q) begin
      case (op_e'(cmd_q.op))
        OP_JUMP, OP_DRAW: begin
          if (swap_pending_q || back_len_q == LEN_W'(DEPTH)) begin
            overflow_d = 1'b1;
          end else begin
            wr_en_c    = 1'b1;
            back_len_d = back_len_q + LEN_W'(1);
          end
        end
        OP_EOF: begin
          if (!swap_pending_q && back_len_q != '0) swap_pending_d = 1'b1;
        end
        default: begin
          back_len_d     = '0;
          overflow_d     = 1'b0;
          swap_pending_d = 1'b0;
        end
      endcase
    end
  end

  // Replay FSM: FETCH -> HOLD (wait ready) -> ISSUE -> 2x BLANK -> next index.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blank_d       = blank_q;
    x_d           = x_q;
    y_d           = y_q;
    draw_d        = 1'b0;
    jump_d        = 1'b0;
    frame_start_d = 1'b0;
    swap_c        = 1'b0;
    rd_en_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (front_len_q == '0 && swap_pending_q) begin
          swap_c  = 1'b1;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en_c = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (ready) begin
          x_d           = rd_data.x;
          y_d           = rd_data.y;
          draw_d        = rd_data.is_draw;
          jump_d        = ~rd_data.is_draw;
          frame_start_d = (idx_q == '0);
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        blank_d = 1'b0;
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!blank_q) begin
          blank_d = 1'b1;
        end else begin
          if (LEN_W'(idx_q) == front_len_q - LEN_W'(1)) begin
            idx_d  = '0;
            swap_c = swap_pending_q;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q     <= '0;
      op_q           <= '0;
      xy_q           <= '0;
      timer_q        <= '0;
      cmd_vld_q      <= 1'b0;
      cmd_q          <= '0;
      front_sel_q    <= 1'b0;
      front_len_q    <= '0;
      back_len_q     <= '0;
      swap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      blank_q        <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      draw_q         <= 1'b0;
      jump_q         <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      op_q           <= op_d;
      xy_q           <= xy_d;
      timer_q        <= timer_d;
      cmd_vld_q      <= cmd_vld_d;
      cmd_q          <= cmd_d;
      front_sel_q    <= front_sel_d;
      front_len_q    <= front_len_d;
      back_len_q     <= back_len_d;
      swap_pending_q <= swap_pending_d;
      overflow_q     <= overflow_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      blank_q        <= blank_d;
      x_q            <= x_d;
      y_q            <= y_d;
      draw_q         <= draw_d;
      jump_q         <= jump_d;
      frame_start_q  <= frame_start_d;
    end
  end

  vector_list_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr ({~front_sel_q, back_len_q[ADDR_W-1:0]}),
    .wr_data (wr_data_c),
    .rd_en   (rd_en_c),
    .rd_addr ({front_sel_q, idx_q}),
    .rd_data (rd_data)
  );

  assign x            = x_q;
  assign y            = y_q;
  assign draw         = draw_q;
  assign jump         = jump_q;
  assign swap_pending = swap_pending_q;
  assign overflow     = overflow_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Self-checking bench: directed scenarios plus randomized command streams,
// checked every cycle against a list-level model of the double buffer.
module tb_vector_list_sequencer;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        ready = 1'b0;
  logic [11:0] x, y;
  logic        draw, jump, swap_pending, overflow, frame_start;

  always #5 clk = ~clk;

  vector_list_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .ready        (ready),
    .x            (x),
    .y            (y),
    .draw         (draw),
    .jump         (jump),
    .swap_pending (swap_pending),
    .overflow     (overflow),
    .frame_start  (frame_start)
  );

  typedef struct packed {
    logic        d;
    logic [11:0] x;
    logic [11:0] y;
  } ent_t;

  // Reference model: front/back lists, pending/overflow flags, replay pointer.
  ent_t        front[$];
  ent_t        back[$];
  bit          m_pending, m_ovf, pend_pre, ready_low_seen;
  int          ptr, wrap_cd, cyc, last_pulse, pulses;
  logic [11:0] last_x, last_y;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    front = {}; back = {};
    m_pending = 1'b0; m_ovf = 1'b0; pend_pre = 1'b0;
    ptr = 0; wrap_cd = 0; last_pulse = -1; ready_low_seen = 1'b0;
    last_x = '0; last_y = '0;
  endtask

  task automatic model_swap();
    front = back;
    back = {};
    m_pending = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Command takes effect in the cycle after its last byte, seeing pre-swap state.
  task automatic model_cmd(input logic [1:0] op, input logic [11:0] cx, input logic [11:0] cy);
    ent_t e;
    case (op)
      2'b00, 2'b01: begin
        if (pend_pre || back.size() == DEPTH) m_ovf = 1'b1;
        else begin
          e.d = op[0]; e.x = cx; e.y = cy;
          back.push_back(e);
        end
      end
      2'b10: if (!pend_pre && back.size() > 0) m_pending = 1'b1;
      default: begin back = {}; m_pending = 1'b0; m_ovf = 1'b0; end
    endcase
  endtask

  task automatic monitor();
    ent_t e;
    if (ready !== 1'b1) ready_low_seen = 1'b1;
    chk("swap_pending", 32'(swap_pending), 32'(m_pending));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("draw_and_jump", 32'(draw & jump), 32'd0);
    if (wrap_cd > 0) begin
      wrap_cd--;
      if (wrap_cd == 0 && m_pending) model_swap();
    end
    if (m_pending && front.size() == 0) model_swap();
    if (draw | jump) begin
      pulses++;
      if (front.size() == 0) begin
        chk("pulse_without_list", 32'(draw | jump), 32'd0);
      end else begin
        e = front[ptr];
        chk("pulse_x", 32'(x), 32'(e.x));
        chk("pulse_y", 32'(y), 32'(e.y));
        chk("pulse_draw", 32'(draw), 32'(e.d));
        chk("pulse_jump", 32'(jump), 32'(!e.d));
        chk("frame_start", 32'(frame_start), 32'(ptr == 0));
        if (last_pulse >= 0 && !ready_low_seen) chk("pulse_spacing", 32'(cyc - last_pulse), 32'd5);
        last_x = e.x; last_y = e.y;
        if (ptr == front.size() - 1) begin ptr = 0; wrap_cd = 2; end
        else ptr++;
      end
      last_pulse = cyc;
      ready_low_seen = 1'b0;
    end else begin
      chk("idle_frame_start", 32'(frame_start), 32'd0);
      chk("hold_x", 32'(x), 32'(last_x));
      chk("hold_y", 32'(y), 32'(last_y));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pend_pre = m_pending;
    monitor();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [11:0] cx, input logic [11:0] cy, input int gap);
    logic [31:0] w;
    w = {op, 6'($urandom), cx, cy};
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (i == 0) model_cmd(op, cx, cy);
      repeat (gap) tick();
    end
  endtask

  initial begin
    int p0;
    bit rand_ready;
    cyc = 0; pulses = 0;
    model_reset();

    // Reset, then idle with ready high.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    ready = 1'b1;
    repeat (1000) tick();
    chk("idle_no_pulses", 32'(pulses), 32'd0);
    chk("idle_x", 32'(x), 32'd0);

    // Load and replay a jump/draw frame.
    send_cmd(2'b00, 12'd4095, 12'd400, 0);
    send_cmd(2'b01, 12'd0, 12'd3695, 1);
    send_cmd(2'b10, 12'd0, 12'd0, 0);
    p0 = pulses;
    repeat (60) tick();
    chk("replay_pulse_count", 32'(pulses - p0 >= 8), 32'd1);

    // Load a 3-entry frame during replay of the 2-entry one.
    for (int i = 0; i < 3; i++) send_cmd(2'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), int'($urandom_range(0, 2)));
    send_cmd(2'b10, 12'($urandom), 12'($urandom), 0);
    repeat (80) tick();

    // Overflow: five draws into a four-entry buffer.
    for (int i = 0; i < 5; i++) send_cmd(2'b01, 12'(i * 7), 12'(i * 11), 0);
    tick();
    chk("overflow_set", 32'(overflow), 32'd1);
    send_cmd(2'b10, 12'd0, 12'd0, 0);
    repeat (100) tick();

    // Timeout resync after a partial command.
    send_byte(8'h40);
    send_byte(8'h12);
    repeat (TIMEOUT + 1) tick();
    send_cmd(2'b01, 12'd100, 12'd200, 0);
    send_cmd(2'b10, 12'd0, 12'd0, 0);
    repeat (60) tick();
    chk("timeout_frame_x", 32'(x), 32'd100);
    chk("timeout_frame_y", 32'(y), 32'd200);

    // Randomized streams with optional clear, random lengths and ready throttling.
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(0, 6));
      rand_ready = 1'($urandom_range(0, 1));
      ready = 1'b1;
      if ($urandom_range(0, 3) == 0) send_cmd(2'b11, 12'($urandom), 12'($urandom), 0);
      for (int i = 0; i < n; i++) begin
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
        send_cmd(2'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), int'($urandom_range(0, 2)));
      end
      if ($urandom_range(0, 4) != 0) send_cmd(2'b10, 12'($urandom), 12'($urandom), int'($urandom_range(0, 1)));
      for (int i = 0; i < 100; i++) begin
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    // Ready throttling, then reset in the middle of BLANK.
    ready = 1'b0;
    p0 = pulses;
    repeat (50) tick();
    chk("throttle_no_pulse", 32'(pulses - p0), 32'd0);
    ready = 1'b1;
    tick();
    chk("release_pulse", 32'(draw | jump), 32'd1);
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_draw", 32'(draw), 32'd0);
    chk("rst_jump", 32'(jump), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    p0 = pulses;
    repeat (100) tick();
    chk("post_reset_no_pulse", 32'(pulses - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
